// File: rtl/minipic.sv
// minipic: four-source edge-triggered interrupt controller.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an enabled pending source
// ASSERT | irq_out high, presenting irq_id; waiting for ack or timeout
// GAP    | one forced low cycle on irq_out before the next arbitration
module minipic #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic       write_enable,
    input  logic [3:0] mask_in,
    input  logic       ack,
    output logic       irq_out,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  irq_prev;
    logic [3:0]  rise_r;
    logic [3:0]  mask;
    logic [15:0] wait_cnt, wait_nxt;
    logic        irq_out_nxt;
    logic [1:0]  irq_id_nxt;
    logic        timeout_nxt;
    logic [3:0]  ack_clr;
    logic [3:0]  req;
    logic [1:0]  low_idx;
    logic [3:0]  ovr_set;

    assign req     = pending & mask;
    // A new edge on a source only counts as overrun if its pending bit survives this cycle.
    assign ovr_set = rise_r & pending & ~ack_clr;

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        low_idx = 2'd0;
        if (req[0])      low_idx = 2'd0;
        else if (req[1]) low_idx = 2'd1;
        else if (req[2]) low_idx = 2'd2;
        else if (req[3]) low_idx = 2'd3;
    end

    // Next-state and registered-output logic for the presentation FSM.
    always_comb begin
        state_nxt   = state;
        irq_out_nxt = irq_out;
        irq_id_nxt  = irq_id;
        wait_nxt    = wait_cnt;
        timeout_nxt = 1'b0;
        ack_clr     = 4'b0000;
        case (state)
            IDLE: begin
                if (|req) begin
                    irq_id_nxt  = low_idx;
                    irq_out_nxt = 1'b1;
                    wait_nxt    = 16'd0;
                    state_nxt   = ASSERT;
                end
            end
            ASSERT: begin
                if (ack) begin
                    ack_clr     = 4'b0001 << irq_id;
                    irq_out_nxt = 1'b0;
                    state_nxt   = GAP;
                end else if (wait_cnt == ACK_TIMEOUT - 16'd1) begin
                    irq_out_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = GAP;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                irq_out_nxt = 1'b0;
            end
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            irq_out  <= 1'b0;
            irq_id   <= 2'd0;
            wait_cnt <= 16'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            irq_out  <= irq_out_nxt;
            irq_id   <= irq_id_nxt;
            wait_cnt <= wait_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Edge detect, pending/overrun bookkeeping and mask register.
    // A new rise beats the ack clear on the same bit; an overrun set beats the write clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev <= 4'b0000;
            rise_r   <= 4'b0000;
            pending  <= 4'b0000;
            overrun  <= 4'b0000;
            mask     <= 4'hF;
        end else begin
            irq_prev <= irq_in;
            rise_r   <= irq_in & ~irq_prev;
            pending  <= (pending & ~ack_clr) | rise_r;
            if (write_enable) begin
                overrun <= ovr_set;
                mask    <= mask_in;
            end else begin
                overrun <= overrun | ovr_set;
            end
        end
    end

endmodule

// File: tb/tb_minipic.sv
// Directed self-checking bench for minipic (ACK_TIMEOUT overridden to 4).
// Observed vector layout: {irq_out, irq_id[1:0], pending[3:0], overrun[3:0], timeout}.
module tb_minipic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_in;
    logic       write_enable;
    logic [3:0] mask_in;
    logic       ack;
    logic       irq_out;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_v;

    minipic #(.ACK_TIMEOUT(16'd4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .write_enable (write_enable),
        .mask_in      (mask_in),
        .ack          (ack),
        .irq_out      (irq_out),
        .irq_id       (irq_id),
        .pending      (pending),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {irq_out, irq_id, pending, overrun, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = 4'h0; write_enable = 1'b0; mask_in = 4'h0; ack = 1'b0;
        tick(); tick();
        exp_v = {1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs(), exp_v); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_single_pulse();
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000;
        exp_v = {1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_k: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_k1: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0;
        exp_v = {1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_k2_ack_idle: got %b want %b", obs(), exp_v); end
        tick(); tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_hold: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0;
        exp_v = {1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_ack: got %b want %b", obs(), exp_v); end
        tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL pulse_gap: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010; tick();
        irq_in = 4'b0000; tick();
        exp_v = {1'b0, 2'd0, 4'b1010, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_pending: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b1, 2'd1, 4'b1010, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_first: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0;
        exp_v = {1'b0, 2'd1, 4'b1000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_ack1: got %b want %b", obs(), exp_v); end
        tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_low_cycle: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_second: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0;
        exp_v = {1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL prio_ack3: got %b want %b", obs(), exp_v); end
        tick();
    endtask

    task automatic test_overrun();
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; tick(); tick();
        exp_v = {1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL ovr_present: got %b want %b", obs(), exp_v); end
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; tick();
        exp_v = {1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL ovr_set: got %b want %b", obs(), exp_v); end
        ack = 1'b1; write_enable = 1'b1; mask_in = 4'hF; tick();
        ack = 1'b0; write_enable = 1'b0;
        exp_v = {1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL ovr_clear: got %b want %b", obs(), exp_v); end
        tick();
    endtask

    task automatic test_ack_coincide();
        irq_in = 4'b0010; tick();
        irq_in = 4'b0000; tick(); tick();
        exp_v = {1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL coin_present: got %b want %b", obs(), exp_v); end
        irq_in = 4'b0010; tick();
        irq_in = 4'b0000; ack = 1'b1; tick();
        ack = 1'b0;
        exp_v = {1'b0, 2'd1, 4'b0010, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL coin_set_wins: got %b want %b", obs(), exp_v); end
        tick(); tick();
        exp_v = {1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL coin_represent: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0; tick();
    endtask

    task automatic test_masking();
        write_enable = 1'b1; mask_in = 4'b1110; tick();
        write_enable = 1'b0;
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000; tick();
        exp_v = {1'b0, 2'd1, 4'b0001, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mask_pending: got %b want %b", obs(), exp_v); end
        tick(); tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mask_held_low: got %b want %b", obs(), exp_v); end
        write_enable = 1'b1; mask_in = 4'hF; tick();
        write_enable = 1'b0;
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mask_write_edge: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL mask_unmasked: got %b want %b", obs(), exp_v); end
        ack = 1'b1; tick();
        ack = 1'b0; tick();
    endtask

    task automatic test_timeout();
        irq_in = 4'b1000; tick();
        irq_in = 4'b0000; tick(); tick();
        exp_v = {1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL to_high_%0d: got %b want %b", i, obs(), exp_v); end
            if (i < 3) tick();
        end
        tick();
        exp_v = {1'b0, 2'd3, 4'b1000, 4'b0000, 1'b1};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL to_pulse: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b0, 2'd3, 4'b1000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL to_pulse_end: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL to_represent: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_reset_mid_assert();
        rst_n = 1'b0; irq_in = 4'hF; tick();
        exp_v = {1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_mid: got %b want %b", obs(), exp_v); end
        tick();
        rst_n = 1'b1; tick();
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_rel_edge: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b0, 2'd0, 4'b1111, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_rel_pending: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = {1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0};
        n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rst_rel_present: got %b want %b", obs(), exp_v); end
        irq_in = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_priority();
        test_overrun();
        test_ack_coincide();
        test_masking();
        test_timeout();
        test_reset_mid_assert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minipic.md
MINIPIC -- requirements
Module: minipic

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16'd255: number of cycles irq_out waits for ack before being withdrawn; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port irq_in, input, 4: interrupt request lines from sources 0..3 (e.g. minipit interrupting on bit 0); rising-edge sensitive.
REQ-005 SHALL have port write_enable, input, 1: when high, loads mask_in and clears overrun.
REQ-006 SHALL have port mask_in, input, 4: enable mask; bit=1 enables the source.
REQ-007 SHALL have port ack, input, 1: host acknowledge of the currently presented interrupt.
REQ-008 SHALL have port irq_out, output, 1: interrupt request to host, held until ack or timeout.
REQ-009 SHALL have port irq_id, output, 2: index of the presented source; valid while irq_out=1.
REQ-010 SHALL have port pending, output, 4: latched pending bits, masked and unmasked.
REQ-011 SHALL have port overrun, output, 4: sticky per-source flag, set on an edge while already pending.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse when an ack timeout occurs.

Function
REQ-013 SHALL detect edges as rise = irq_in & ~irq_prev, where irq_prev holds irq_in registered each cycle; a level held high counts as one edge.
REQ-014 SHALL set pending[i] on the edge after the edge at which rise[i]=1 is sampled.
REQ-015 SHALL set overrun[i] when rise[i]=1 and pending[i]=1 and pending[i] is not being cleared in the same cycle.
REQ-016 SHALL, when write_enable=1, load mask <= mask_in and clear overrun to 4'b0 in that cycle; a coincident overrun set SHALL take priority over the clear.
REQ-017 SHALL implement FSM states IDLE, ASSERT, GAP.
REQ-018 In IDLE, when (pending & mask) != 0, the FSM SHALL select the lowest set index, register irq_id, set irq_out=1, zero the wait counter, and enter ASSERT.
REQ-019 In ASSERT with ack=1, the FSM SHALL clear pending[irq_id], drive irq_out=0, and enter GAP.
REQ-020 In ASSERT with ack=0, the FSM SHALL increment the 16-bit wait counter; when the counter equals ACK_TIMEOUT-1, it SHALL drive irq_out=0, pulse timeout for 1 cycle, keep pending, and enter GAP.
REQ-021 GAP SHALL last exactly 1 cycle and then enter IDLE, guaranteeing at least 1 low cycle on irq_out between interrupts.
REQ-022 Latency: with an edge sampled at clock edge k, the FSM in IDLE, and no higher-priority source pending, pending SHALL be 1 after edge k+1 and irq_out SHALL be 1 after edge k+2.
REQ-023 If a rise on irq_id's source coincides with the ack clear, the set SHALL win: pending stays 1 and overrun is not set.
REQ-024 ack in IDLE or GAP SHALL be ignored.
REQ-025 Mask changes during ASSERT SHALL NOT withdraw or alter the presented irq_id.
REQ-026 Masked pending bits SHALL be retained and serviced once unmasked.
REQ-027 irq_id SHALL hold its last value while irq_out=0.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, irq_out=0, irq_id=0, pending=0, overrun=0, timeout=0, irq_prev=0, wait counter=0, mask=4'hF.
REQ-029 Reset SHALL override all other inputs, including mid-ASSERT, and SHALL drop irq_out on the same edge.
REQ-030 irq_in already high when reset releases SHALL count as an edge (irq_prev=0).

Verification
REQ-031 Single pulse: 1-cycle pulse on irq_in[0] at edge k -> pending=4'b0001 at k+1, irq_out=1 and irq_id=0 at k+2; ack 3 cycles later -> pending=0, irq_out=0, GAP observed.
REQ-032 Priority: pulses on irq_in[3] and irq_in[1] in the same cycle -> irq_id=1 first; after ack and GAP, irq_id=3 is presented; 1 low cycle between.
REQ-033 Overrun: second irq_in[2] edge while pending[2]=1 -> overrun=4'b0100; write_enable with mask_in=4'hF -> overrun=0.
REQ-034 Masking: mask=4'b1110, pulse on irq_in[0] -> pending[0]=1 and irq_out stays 0; write mask 4'hF -> irq_out=1 with irq_id=0 two cycles later.
REQ-035 Timeout: ACK_TIMEOUT=4, no ack -> irq_out high 4 cycles, timeout pulses 1 cycle, pending kept, re-presented after GAP.
REQ-036 Reset mid-ASSERT: rst_n=0 while irq_out=1 -> all outputs at reset values on the next edge.
